// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle for onehot_scan_encoder: request vector in, index beats out.
interface onehot_scan_encoder_if #(parameter int N = 8);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] d;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic         last;
    logic         none;
    logic         err;

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q, last, none, err
    );

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q, last, none, err
    );
endinterface

// File: rtl/onehot_scan_encoder.sv
// Registered scan encoder: emits the index of every set bit of d, lowest first, one beat per cycle.
// Define ENC_STRICT_ONEHOT_EN to reject multi-hot vectors with a single err beat.
module onehot_scan_encoder #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   En,
    onehot_scan_encoder_if.slave   bus
);
    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_pend,  w_pend_nxt;
    logic         r_none,  w_none_nxt;
    logic         r_err,   w_err_nxt;
    logic [W-1:0] w_idx;
    logic         w_single;
    logic         w_multi_d;
    logic         w_valid;

`ifdef ENC_STRICT_ONEHOT_EN
    assign w_multi_d = (bus.d & (bus.d - ONE)) != '0;
`else
    assign w_multi_d = 1'b0;
`endif

    // Highest-to-lowest loop so the lowest set bit wins.
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) w_idx = W'(i);
        end
    end

    assign w_single = (r_pend & (r_pend - ONE)) == '0;
    assign w_valid  = (r_state == SCAN);

    assign bus.in_ready  = En && (r_state == IDLE);
    assign bus.out_valid = w_valid;
    assign bus.q         = w_valid ? w_idx : '0;
    assign bus.last      = w_valid & w_single;
    assign bus.none      = w_valid & r_none;
    assign bus.err       = w_valid & r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_none_nxt  = r_none;
        w_err_nxt   = r_err;
        if (!En) begin
            w_state_nxt = IDLE;
            w_pend_nxt  = '0;
            w_none_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // A rejected multi-hot vector scans as an empty pend: q = 0, last = 1.
                        w_state_nxt = SCAN;
                        w_pend_nxt  = w_multi_d ? '0 : bus.d;
                        w_none_nxt  = (bus.d == '0);
                        w_err_nxt   = w_multi_d;
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        if (w_single) begin
                            w_state_nxt = IDLE;
                            w_pend_nxt  = '0;
                            w_none_nxt  = 1'b0;
                            w_err_nxt   = 1'b0;
                        end else begin
                            w_pend_nxt  = r_pend & (r_pend - ONE);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_none  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_none  <= w_none_nxt;
            r_err   <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed-vector bench for onehot_scan_encoder (N = 8) with immediate-assertion checks.
module tb_onehot_scan_encoder;
    logic clk;
    logic rst_n;
    logic En;
    int   n_vec;
    int   n_err;

    onehot_scan_encoder_if #(.N(8)) bus ();

    onehot_scan_encoder #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .En    (En),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one output beat: valid, q, last, none, err.
    task automatic beat(input string tag, input logic v, input logic [2:0] q,
                        input logic l, input logic n, input logic e);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".q"},     32'(bus.q),         32'(q));
        chk({tag, ".last"},  32'(bus.last),      32'(l));
        chk({tag, ".none"},  32'(bus.none),      32'(n));
        chk({tag, ".err"},   32'(bus.err),       32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        En = 1'b0;
        bus.in_valid = 1'b0;
        bus.d = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        beat("rst", 0, 0, 0, 0, 0);
        chk("rst.in_ready_en0", 32'(bus.in_ready), 0);
        En = 1'b1;
        #1;
        chk("rst.in_ready_en1", 32'(bus.in_ready), 1);
        rst_n = 1'b1;

        // One-hot 0x20
        bus.in_valid = 1'b1; bus.d = 8'h20; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        beat("oh", 1, 5, 1, 0, 0);
        chk("oh.in_ready_busy", 32'(bus.in_ready), 0);
        tick();
        chk("oh.done_valid", 32'(bus.out_valid), 0);
        chk("oh.in_ready_after", 32'(bus.in_ready), 1);

`ifndef ENC_STRICT_ONEHOT_EN
        // Multi-hot scan 0x85
        bus.in_valid = 1'b1; bus.d = 8'h85;
        tick();
        bus.in_valid = 1'b0; bus.d = 8'h40;
        beat("mh0", 1, 0, 0, 0, 0);
        tick();
        beat("mh1", 1, 2, 0, 0, 0);
        tick();
        beat("mh2", 1, 7, 1, 0, 0);
        tick();
        chk("mh.done", 32'(bus.out_valid), 0);

        // Backpressure on the second beat
        bus.in_valid = 1'b1; bus.d = 8'h85;
        tick();
        bus.in_valid = 1'b0;
        beat("bp0", 1, 0, 0, 0, 0);
        tick();
        bus.out_ready = 1'b0;
        beat("bp1", 1, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            beat("bp_hold", 1, 2, 0, 0, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        beat("bp2", 1, 7, 1, 0, 0);
        tick();
        chk("bp.done", 32'(bus.out_valid), 0);
`endif

        // Zero vector
        bus.in_valid = 1'b1; bus.d = 8'h00;
        tick();
        bus.in_valid = 1'b0;
        beat("zero", 1, 0, 1, 1, 0);
        tick();
        beat("zero_done", 0, 0, 0, 0, 0);
        chk("zero.in_ready", 32'(bus.in_ready), 1);

`ifndef ENC_STRICT_ONEHOT_EN
        // Flush: 0xFF, drop En after two beats
        bus.in_valid = 1'b1; bus.d = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        beat("fl0", 1, 0, 0, 0, 0);
        tick();
        beat("fl1", 1, 1, 0, 0, 0);
        tick();
        beat("fl2", 1, 2, 0, 0, 0);
        En = 1'b0;
        #1;
        chk("fl.in_ready_en0", 32'(bus.in_ready), 0);
        tick();
        beat("fl.flushed", 0, 0, 0, 0, 0);
        chk("fl.in_ready_still0", 32'(bus.in_ready), 0);
        En = 1'b1;
        #1;
        chk("fl.in_ready_back", 32'(bus.in_ready), 1);
        tick();
        chk("fl.no_more", 32'(bus.out_valid), 0);
`else
        // Strict: multi-hot rejected with a single err beat
        bus.in_valid = 1'b1; bus.d = 8'h81;
        tick();
        bus.in_valid = 1'b0;
        beat("st_err", 1, 0, 1, 0, 1);
        tick();
        beat("st_err_done", 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1; bus.d = 8'h80;
        tick();
        bus.in_valid = 1'b0;
        beat("st_oh", 1, 7, 1, 0, 0);
        tick();
        chk("st_oh.done", 32'(bus.out_valid), 0);
`endif

        // Async reset mid-scan
        bus.in_valid = 1'b1; bus.d = 8'h0C;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        beat("ar0", 1, 2, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        beat("ar.reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk("ar.no_beat", 32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
